// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - MEM-stage data RAM responder with byte lanes, wait states and fault detection
module dmem_responder #(
    parameter int          ADDR_WIDTH  = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0002_0000,
    parameter int          WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_memSize,
    output logic [31:0] o_rdata,
    output logic        o_ready,
    output logic        o_fault,
    output logic        o_busy
);
    localparam int          DEPTH   = 1 << ADDR_WIDTH;
    localparam logic [3:0]  WS_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  size_q;

    logic [31:0] mem [0:DEPTH-1];

    // In IDLE the live request is decoded so a zero-wait access can read the RAM on its acceptance edge.
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [1:0]  sel_size;
    logic [29:0] off_w;
    logic [ADDR_WIDTH-1:0] idx;
    logic        acc_fault;
    logic [3:0]  wmask;
    logic [31:0] wdata_sh;
    logic [31:0] rword;
    logic [31:0] load_data;

    always_comb begin
        sel_we    = (state == IDLE) ? i_we      : we_q;
        sel_addr  = (state == IDLE) ? i_addr    : addr_q;
        sel_wdata = (state == IDLE) ? i_wdata   : wdata_q;
        sel_size  = (state == IDLE) ? i_memSize : size_q;
    end

    // Unsigned word offset: addresses below the base wrap to a huge value and land in the range fault.
    assign off_w = sel_addr[31:2] - BASE_ADDR[31:2];
    assign idx   = off_w[ADDR_WIDTH-1:0];
    assign rword = mem[idx];

    always_comb begin
        acc_fault = (|off_w[29:ADDR_WIDTH]);
        case (sel_size)
            2'b01:   acc_fault = acc_fault | sel_addr[0];
            2'b10:   acc_fault = acc_fault | (|sel_addr[1:0]);
            2'b11:   acc_fault = 1'b1;
            default: acc_fault = acc_fault;
        endcase
    end

    always_comb begin
        wmask     = 4'b0000;
        wdata_sh  = 32'd0;
        load_data = 32'd0;
        case (sel_size)
            2'b00: begin
                wmask     = 4'b0001 << sel_addr[1:0];
                wdata_sh  = {4{sel_wdata[7:0]}};
                load_data = {24'd0, rword[{sel_addr[1:0], 3'b000} +: 8]};
            end
            2'b01: begin
                wmask     = sel_addr[1] ? 4'b1100 : 4'b0011;
                wdata_sh  = {2{sel_wdata[15:0]}};
                load_data = {16'd0, rword[{sel_addr[1], 4'b0000} +: 16]};
            end
            2'b10: begin
                wmask     = 4'b1111;
                wdata_sh  = sel_wdata;
                load_data = rword;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            o_rdata <= 32'd0;
            o_ready <= 1'b0;
            o_fault <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    o_ready <= 1'b0;
                    o_fault <= 1'b0;
                    o_rdata <= 32'd0;
                    if (i_req) begin
                        we_q    <= i_we;
                        addr_q  <= i_addr;
                        wdata_q <= i_wdata;
                        size_q  <= i_memSize;
                        if (WAIT_STATES == 0) begin
                            state   <= RESP;
                            o_ready <= 1'b1;
                            o_fault <= acc_fault;
                            o_rdata <= (acc_fault || sel_we) ? 32'd0 : load_data;
                        end else begin
                            state <= WAIT;
                            cnt   <= WS_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state   <= RESP;
                        o_ready <= 1'b1;
                        o_fault <= acc_fault;
                        o_rdata <= (acc_fault || sel_we) ? 32'd0 : load_data;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    state   <= IDLE;
                    o_ready <= 1'b0;
                    o_fault <= 1'b0;
                    o_rdata <= 32'd0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stores commit on the edge leaving RESP; reset on that edge wins and drops the store.
    always_ff @(posedge clk) begin
        if (!reset && state == RESP && we_q && !acc_fault) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask[b]) mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
            end
        end
    end

    assign o_busy = i_req & ~o_ready;
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder at 0, 1 and 3 wait states
module tb_dmem_responder;
    localparam logic [31:0] BASE   = 32'h0002_0000;
    localparam int          WS_TAB [3] = '{1, 0, 3};

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset [3];
    logic        req   [3];
    logic        we    [3];
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [1:0]  msize [3];
    logic [31:0] rdata [3];
    logic        ready [3];
    logic        fault [3];
    logic        busy  [3];

    int total = 0;
    int bad   = 0;
    exp_t sb [$];
    logic [7:0] mdl [int];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dmem_responder #(.ADDR_WIDTH(10), .BASE_ADDR(BASE), .WAIT_STATES(WS_TAB[g])) u_dut (
            .clk       (clk),
            .reset     (reset[g]),
            .i_req     (req[g]),
            .i_we      (we[g]),
            .i_addr    (addr[g]),
            .i_wdata   (wdata[g]),
            .i_memSize (msize[g]),
            .o_rdata   (rdata[g]),
            .o_ready   (ready[g]),
            .o_fault   (fault[g]),
            .o_busy    (busy[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push_expect(input int k, input logic w, input logic [31:0] a,
                               input logic [31:0] d, input logic [1:0] s);
        exp_t        e;
        logic [31:0] off;
        logic        flt;
        int          n;
        off = a - BASE;
        flt = (s == 2'b11) || (s == 2'b01 && a[0]) || (s == 2'b10 && a[1:0] != 2'b00)
              || (off >= 32'd4096);
        n = (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
        e.rdata = 32'd0;
        e.fault = flt;
        if (!flt) begin
            for (int i = 0; i < n; i++) begin
                int key;
                key = k * 65536 + int'(off) + i;
                if (w) mdl[key] = d[8*i +: 8];
                else   e.rdata[8*i +: 8] = mdl.exists(key) ? mdl[key] : 8'h00;
            end
        end
        sb.push_back(e);
    endtask

    task automatic drive(input int k, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [1:0] s);
        req[k]   = 1'b1;
        we[k]    = w;
        addr[k]  = a;
        wdata[k] = d;
        msize[k] = s;
    endtask

    task automatic access(input int k, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [1:0] s, input string tag);
        int   lat;
        exp_t e;
        @(negedge clk);
        drive(k, w, a, d, s);
        push_expect(k, w, a, d, s);
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (ready[k]) begin
                lat = c;
                break;
            end
            check({tag, "_busy"}, 32'(busy[k]), 32'd1);
        end
        check({tag, "_lat"}, lat, WS_TAB[k] + 1);
        check({tag, "_busy_rdy"}, 32'(busy[k]), 32'd0);
        e = sb.pop_front();
        check({tag, "_rdata"}, rdata[k], e.rdata);
        check({tag, "_fault"}, 32'(fault[k]), 32'(e.fault));
        req[k] = 1'b0;
    endtask

    initial begin
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            reset[k] = 1'b1;
            drive(k, 1'b0, 32'd0, 32'd0, 2'b00);
            req[k] = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) reset[k] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("rst_ready", 32'(ready[k]), 32'd0);
            check("rst_fault", 32'(fault[k]), 32'd0);
            check("rst_rdata", rdata[k], 32'd0);
            check("rst_busy", 32'(busy[k]), 32'd0);
        end

        access(0, 1'b1, BASE + 8,  32'hDEADBEEF, 2'b10, "st_w8");
        access(0, 1'b0, BASE + 8,  32'h0,        2'b10, "ld_w8");
        access(0, 1'b1, BASE + 9,  32'hFFFF_FF11, 2'b00, "st_b9");
        access(0, 1'b1, BASE + 10, 32'hFFFF_2233, 2'b01, "st_h10");
        access(0, 1'b0, BASE + 8,  32'h0,        2'b10, "ld_w8b");
        access(0, 1'b0, BASE + 11, 32'h0,        2'b00, "ld_b11");
        access(0, 1'b0, BASE + 8,  32'h0,        2'b01, "ld_h8");
        access(0, 1'b1, BASE + 4,  32'h0102_0304, 2'b10, "st_w4");
        access(0, 1'b0, BASE + 1,  32'h0,        2'b01, "ld_h1");
        access(0, 1'b1, BASE + 6,  32'h5555_AAAA, 2'b10, "st_w6");
        access(0, 1'b0, BASE + 4,  32'h0,        2'b10, "ld_w4");
        access(0, 1'b0, BASE - 4,  32'h0,        2'b10, "ld_below");
        access(0, 1'b0, BASE + 4096, 32'h0,      2'b10, "ld_above");
        access(0, 1'b0, BASE + 12, 32'h0,        2'b11, "ld_sz3");

        access(0, 1'b1, BASE + 16, 32'h1234_5678, 2'b10, "st_w16");
        @(negedge clk);
        drive(0, 1'b1, BASE + 16, 32'hCAFEF00D, 2'b10);
        @(negedge clk);
        check("rstmid_wait_rdy", 32'(ready[0]), 32'd0);
        reset[0] = 1'b1;
        req[0]   = 1'b0;
        @(negedge clk);
        check("rstmid_ready", 32'(ready[0]), 32'd0);
        check("rstmid_fault", 32'(fault[0]), 32'd0);
        check("rstmid_rdata", rdata[0], 32'd0);
        check("rstmid_busy", 32'(busy[0]), 32'd0);
        reset[0] = 1'b0;
        access(0, 1'b0, BASE + 16, 32'h0, 2'b10, "ld_w16");

        @(negedge clk);
        drive(0, 1'b0, BASE + 8, 32'h0, 2'b10);
        repeat (3) push_expect(0, 1'b0, BASE + 8, 32'h0, 2'b10);
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            check("held_ready", 32'(ready[0]), 32'((i % 3) == 2));
            check("held_busy", 32'(busy[0]), 32'((i % 3) != 2));
            if (ready[0] && sb.size() > 0) begin
                e = sb.pop_front();
                check("held_rdata", rdata[0], e.rdata);
            end
        end
        req[0] = 1'b0;

        for (int k = 1; k < 3; k++) begin
            access(k, 1'b1, BASE + 0,  32'hA5A5_5A5A, 2'b10, "ws_st");
            access(k, 1'b0, BASE + 0,  32'h0,         2'b10, "ws_ld");
            access(k, 1'b0, BASE + 2,  32'h0,         2'b01, "ws_ldh");
            access(k, 1'b0, BASE + 3,  32'h0,         2'b10, "ws_mis");
        end

        check("sb_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
